// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO and the parity UART it feeds:
// FSM state encodings and the default byte width / queue depth.
package uart_tx_fifo_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int UART_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
// Storage is intentionally not reset; occupancy is tracked by the pointers.
module uart_fifo_mem
   import uart_tx_fifo_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the parity UART: launches one byte per frame once tx_busy is low.
// Optional sent/drop counters are enabled by defining UART_TX_FIFO_STATS_EN.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int  DATA_W       = UART_DATA_W,
   parameter int  DEPTH        = UART_FIFO_DEPTH,
   parameter int  BUSY_TIMEOUT = 4,
   localparam int ADDR_W       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] uart_din,
   output logic              uart_wr_en,
   input  logic              uart_tx_busy,
   output logic [ADDR_W:0]   level,
   output logic              empty,
   output logic              full,
   output logic              overflow
`ifdef UART_TX_FIFO_STATS_EN
   ,
   output logic [15:0]       sent_count,
   output logic [15:0]       drop_count
`endif
);

   localparam logic [3:0]    TIMER_LAST = 4'(BUSY_TIMEOUT - 1);
   localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

   tx_state_t         state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [DATA_W-1:0] rd_data;
   logic [3:0]        timer;
   logic              push, pop;

   assign full     = (level == LEVEL_FULL);
   assign empty    = (level == '0);
   assign wr_ready = !full;
   assign push     = wr_valid && !full;
   // A pop is the launch itself: only from IDLE, and never over an in-flight frame.
   assign pop      = (state == IDLE) && !empty && !uart_tx_busy;

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (pop) state_nxt = LAUNCH;
         LAUNCH:    state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (uart_tx_busy)              state_nxt = WAIT_DONE;
            else if (timer == TIMER_LAST)  state_nxt = IDLE;
         end
         WAIT_DONE: if (!uart_tx_busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         uart_din   <= '0;
         uart_wr_en <= 1'b0;
         overflow   <= 1'b0;
         timer      <= '0;
      end else begin
         state      <= state_nxt;
         uart_wr_en <= pop;
         overflow   <= wr_valid && full;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            uart_din <= rd_data;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
         if (state == LAUNCH)
            timer <= '0;
         else if (state == WAIT_BUSY && !uart_tx_busy)
            timer <= timer + 1'b1;
      end
   end

`ifdef UART_TX_FIFO_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sent_count <= '0;
         drop_count <= '0;
      end else begin
         if (uart_wr_en) sent_count <= sent_count + 1'b1;
         if (overflow)   drop_count <= drop_count + 1'b1;
      end
   end
`endif

endmodule
